// File: rtl/lum_filter_mc_if.sv
// Sample-vector handshake bundle for lum_filter_mc.
// master drives valid_i/value_i/clear_i/coeffs; slave returns ready_o/valid_o/value_o.
interface lum_filter_mc_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
);
  logic                      valid_i;
  logic                      ready_o;
  logic [CHANNELS*WIDTH-1:0] value_i;
  logic                      clear_i;
  logic [15:0]               coeff_rise_i;
  logic [15:0]               coeff_fall_i;
  logic                      valid_o;
  logic [CHANNELS*WIDTH-1:0] value_o;

  modport master (
    output valid_i, value_i, clear_i,
    output coeff_rise_i, coeff_fall_i,
    input  ready_o, valid_o, value_o
  );

  modport slave (
    input  valid_i, value_i, clear_i,
    input  coeff_rise_i, coeff_fall_i,
    output ready_o, valid_o, value_o
  );
endinterface

// File: rtl/lum_filter_mc.sv
// Time-multiplexed multi-channel first-order IIR luminance smoother.
// Ports: clock, reset (async, active-high), bus (lum_filter_mc_if.slave).
// Macro LUM_FILTER_ASYM_EN: separate rise/fall coefficients.
module lum_filter_mc #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
) (
  input  logic         clock,
  input  logic         reset,
  lum_filter_mc_if.slave bus
);
  localparam int YW = WIDTH + 16;
  localparam int DW = WIDTH + 18;
  localparam int PW = DW + 17;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [YW-1:0]             r_y [CHANNELS];
  logic [YW-1:0]             w_y_nxt [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] r_x;
  logic                      r_clr;
  logic [15:0]               r_rise;
  logic [CW-1:0]             r_cnt;

  logic                 r_s1_v, r_s1_last;
  logic [CW-1:0]        r_s1_idx;
  logic signed [DW-1:0] r_s1_d;
  logic [15:0]          r_s1_a;

  logic                 r_s2_v, r_s2_last;
  logic [CW-1:0]        r_s2_idx;
  logic signed [PW-1:0] r_s2_p;

  logic                      r_valid_o;
  logic [CHANNELS*WIDTH-1:0] r_value_o;

  logic                      w_hs, w_issue, w_cnt_last, w_last_wb;
  logic [WIDTH-1:0]          w_x;
  logic signed [DW-1:0]      w_d;
  logic [15:0]               w_alpha;
  logic signed [PW-1:0]      w_inc;
  logic [YW-1:0]             w_ysum;
  logic [CHANNELS*WIDTH-1:0] w_out;

  assign bus.ready_o = (r_state == IDLE);
  assign bus.valid_o = r_valid_o;
  assign bus.value_o = r_value_o;

  assign w_hs       = bus.valid_i & bus.ready_o;
  assign w_issue    = (r_state == RUN);
  assign w_cnt_last = (r_cnt == CW'(CHANNELS - 1));
  assign w_last_wb  = r_s2_v & r_s2_last;

  // S1: signed error between new sample and state
  assign w_x = r_x[r_cnt*WIDTH +: WIDTH];
  assign w_d = $signed({2'b0, w_x, 16'b0})
             - $signed({2'b0, r_y[r_cnt]});

`ifdef LUM_FILTER_ASYM_EN
  logic [15:0] r_fall;
  assign w_alpha = (w_d > 0) ? r_rise : r_fall;
`else
  logic w_unused_fall;
  assign w_unused_fall = ^bus.coeff_fall_i;
  assign w_alpha = r_rise;
`endif

  // S3: rounded arithmetic shift of the product back to Q.16
  assign w_inc  = (r_s2_p + PW'(32768)) >>> 16;
  assign w_ysum = r_y[r_s2_idx] + w_inc[YW-1:0];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) w_y_nxt[k] = r_y[k];
    if (r_s2_v) begin
      if (r_clr)
        w_y_nxt[r_s2_idx] = {r_x[r_s2_idx*WIDTH +: WIDTH], 16'b0};
      else
        w_y_nxt[r_s2_idx] = w_ysum;
    end
  end

  // Output uses the post-write state so the last channel lands
  // in the same cycle that valid_o rises.
  always_comb begin
    logic [YW:0] rnd;
    w_out = '0;
    rnd   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      rnd = {1'b0, w_y_nxt[k]} + (YW+1)'(32768);
      if (rnd[YW:16] > (WIDTH+1)'((1 << WIDTH) - 1))
        w_out[k*WIDTH +: WIDTH] = '1;
      else
        w_out[k*WIDTH +: WIDTH] = rnd[16 +: WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_state_nxt = RUN;
      RUN:     if (w_cnt_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_wb) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_clr  <= 1'b0;
      r_rise <= '0;
`ifdef LUM_FILTER_ASYM_EN
      r_fall <= '0;
`endif
      r_cnt  <= '0;
    end else if (w_hs) begin
      r_x    <= bus.value_i;
      r_clr  <= bus.clear_i;
      r_rise <= bus.coeff_rise_i;
`ifdef LUM_FILTER_ASYM_EN
      r_fall <= bus.coeff_fall_i;
`endif
      r_cnt  <= '0;
    end else if (w_issue) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_idx  <= '0;
      r_s1_d    <= '0;
      r_s1_a    <= '0;
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_idx  <= '0;
      r_s2_p    <= '0;
    end else begin
      r_s1_v    <= w_issue;
      r_s1_last <= w_issue & w_cnt_last;
      r_s1_idx  <= r_cnt;
      r_s1_d    <= w_d;
      r_s1_a    <= w_alpha;
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_last;
      r_s2_idx  <= r_s1_idx;
      r_s2_p    <= r_s1_d * $signed({1'b0, r_s1_a});
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) r_y[k] <= '0;
      r_valid_o <= 1'b0;
      r_value_o <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) r_y[k] <= w_y_nxt[k];
      r_valid_o <= w_last_wb;
      if (w_last_wb) r_value_o <= w_out;
    end
  end
endmodule

// File: tb/tb_lum_filter_mc.sv
// Randomised self-checking bench for lum_filter_mc.
// Reference: per-channel real-valued Q.16 state updated with plain arithmetic.
module tb_lum_filter_mc;
  localparam int W  = 5;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lum_filter_mc_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  lum_filter_mc #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  longint my [CH];

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint mout(input longint y);
    longint r;
    r = (y + 32768) / 65536;
    return (r > 31) ? 31 : r;
  endfunction

  task automatic model(input logic [CH*W-1:0] v, input bit clr,
                       input logic [15:0] ar, input logic [15:0] af);
    longint x, d, a;
    for (int k = 0; k < CH; k++) begin
      x = longint'(v[k*W +: W]);
      if (clr) my[k] = x * 65536;
      else begin
        d = x * 65536 - my[k];
`ifdef LUM_FILTER_ASYM_EN
        a = (d > 0) ? longint'(ar) : longint'(af);
`else
        a = longint'(ar);
        if (af == 16'hFFFF) a = longint'(ar);
`endif
        my[k] = my[k] + ((d * a + 32768) >>> 16);
      end
    end
  endtask

  task automatic do_vec(input logic [CH*W-1:0] v, input bit clr,
                        input logic [15:0] ar, input logic [15:0] af,
                        input bit junk);
    int cyc;
    bit got;
    cyc = 0;
    while (!bus.ready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rdy_pre", bus.ready_o, 1);
    bus.valid_i      = 1'b1;
    bus.value_i      = v;
    bus.clear_i      = clr;
    bus.coeff_rise_i = ar;
    bus.coeff_fall_i = af;
    model(v, clr, ar, af);
    cyc = 0;
    got = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.valid_i = 1'b0;
      if (bus.valid_o) got = 1;
      else begin
        chk("busy_rdy", bus.ready_o, 0);
        if (junk) begin
          bus.valid_i      = 1'($urandom);
          bus.value_i      = CH*W'($urandom);
          bus.clear_i      = 1'($urandom);
          bus.coeff_rise_i = 16'($urandom);
          bus.coeff_fall_i = 16'($urandom);
        end
      end
    end while (!got && cyc < 20);
    bus.valid_i = 1'b0;
    chk("latency", cyc, 7);
    chk("rdy_vo", bus.ready_o, 1);
    for (int k = 0; k < CH; k++)
      chk($sformatf("val%0d", k), bus.value_o[k*W +: W], mout(my[k]));
  endtask

  task automatic chk_const(input string tag, input int e0,
                           input int e1, input int e2, input int e3);
    int e [CH];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < CH; k++)
      chk($sformatf("%s%0d", tag, k), bus.value_o[k*W +: W], e[k]);
  endtask

  function automatic logic [CH*W-1:0] pack(input int a, input int b,
                                           input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  initial begin
    bit seen;
    rst              = 1'b1;
    bus.valid_i      = 1'b0;
    bus.value_i      = '0;
    bus.clear_i      = 1'b0;
    bus.coeff_rise_i = '0;
    bus.coeff_fall_i = '0;
    for (int k = 0; k < CH; k++) my[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.ready_o, 1);
    chk("rst_vo", bus.valid_o, 0);
    chk("rst_val", bus.value_o, 0);
    rst = 1'b0;
    @(negedge clk);

    do_vec(pack(31, 0, 16, 5), 1'b1, 16'd0, 16'd0, 1'b0);
    chk_const("snap", 31, 0, 16, 5);

    for (int i = 0; i < 12; i++)
      do_vec(CH*W'($urandom), ($urandom_range(3) == 0),
             16'($urandom), 16'($urandom), 1'b1);

    do_vec(pack(31, 31, 31, 31), 1'b1, 16'd0, 16'd0, 1'b0);
    bus.valid_i      = 1'b1;
    bus.value_i      = '0;
    bus.clear_i      = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_val", bus.value_o, 0);
    chk("mid_rst_vo", bus.valid_o, 0);
    chk("mid_rst_rdy", bus.ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < CH; k++) my[k] = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.valid_o) seen = 1;
    end
    chk("no_vo_after_rst", seen, 0);

    do_vec(pack(31, 31, 31, 31), 1'b0, 16'd32768, 16'd32768, 1'b0);
    chk_const("step1_", 16, 16, 16, 16);
    do_vec(pack(31, 31, 31, 31), 1'b0, 16'd32768, 16'd32768, 1'b1);
    chk_const("step2_", 23, 23, 23, 23);

    for (int i = 0; i < 10; i++) begin
      do_vec(CH*W'($urandom), 1'b0, 16'd0, 16'd0, 1'b0);
      chk_const("hold", 23, 23, 23, 23);
    end

    do_vec('0, 1'b1, 16'd0, 16'd0, 1'b0);
    do_vec(pack(31, 31, 31, 31), 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    chk_const("track", 31, 31, 31, 31);

    do_vec(pack(31, 31, 31, 31), 1'b0, 16'hFFFF, 16'd0, 1'b0);
    do_vec('0, 1'b0, 16'hFFFF, 16'd0, 1'b0);
`ifdef LUM_FILTER_ASYM_EN
    chk_const("asym", 31, 31, 31, 31);
`else
    chk_const("asym", 0, 0, 0, 0);
`endif

    for (int i = 0; i < 15; i++)
      do_vec(CH*W'($urandom), ($urandom_range(5) == 0),
             16'($urandom), 16'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lum_filter_mc.md
# lum_filter_mc

Multi-channel, time-multiplexed first-order IIR luminance smoother, the parametrised successor to the single-channel fixed-coefficient luminance filter. It accepts one sample vector of CHANNELS values per handshake and updates each channel's Q.16 state with y += alpha·(x − y) through one shared multiplier. Coefficients are runtime inputs, and an optional build feature selects separate rise and fall coefficients. It sits between the ambient-light/luminance measurement path and the backlight/brightness control logic.

## Interface
- WIDTH, 5: bits per channel sample.
- CHANNELS, 4: number of channels, 1..16.
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  sample vector present.
- ready_o  out  1  block can accept a vector. Handshake completes when valid_i & ready_o.
- value_i  in  CHANNELS*WIDTH  input samples; channel k is bits [k*WIDTH +: WIDTH].
- clear_i  in  1  sampled at handshake; 1 = load state directly from input (snap).
- coeff_rise_i  in  16  alpha, Q0.16; weight of the new sample.
- coeff_fall_i  in  16  alpha used when the input is below the state (see Configuration).
- valid_o  out  1  one-cycle pulse when value_o is updated.
- value_o  out  CHANNELS*WIDTH  filtered outputs; same packing as value_i.

## Operation
- State:
  - Per channel, y[k] is WIDTH+16 bits, unsigned, with 16 fraction bits.
  - Storage is a register array, not memory.
- FSM states and transitions:
  - IDLE: ready_o=1. On handshake, register value_i, clear_i and both coefficients, clear the channel counter, and go to RUN.
  - RUN: ready_o=0. Issue channel cnt into the pipeline each cycle. After channel CHANNELS−1 is issued, go to DRAIN.
  - DRAIN: ready_o=0. Wait until the last write-back completes, then pulse valid_o, set ready_o=1 in that same cycle, and go to IDLE.
- Pipeline (per issued channel):
  - S1: d = (x<<16) − y[k], signed, WIDTH+18 bits. Select alpha.
  - S2: p = d·alpha, signed full product.
  - S3: y[k] ← y[k] + ((p + 2^15) >>> 16), arithmetic shift.
  - If the clear flag is set, S3 instead writes y[k] ← x<<16.
- No hazards: each channel is read and written exactly once per vector.
- Output:
  - value_o[k] = (y[k] + 2^15) >> 16, saturated to 2^WIDTH−1.
  - All channels are registered together on the valid_o cycle and held otherwise.
- Coefficient semantics:
  - alpha=0 freezes the channel.
  - alpha=65535 tracks the input within one vector.
  - Coefficient and input changes during RUN/DRAIN have no effect, because they were captured at handshake.
- Reset, including assertion mid-RUN/DRAIN:
  - All y[k]=0, value_o=0, valid_o=0, ready_o=1, FSM=IDLE.
  - Any vector in flight is discarded.
- valid_i while ready_o=0 is ignored. No queueing.

## Timing
- Handshake at cycle 0.
- Channel k is issued at cycle 1+k.
- valid_o pulses at cycle CHANNELS+3, and ready_o is high again in that cycle.
- A new handshake is possible in the valid_o cycle.
- Throughput: one vector per CHANNELS+3 cycles.
- Multiplier latency is fixed at 1 cycle, in S2.

## Configuration
- LUM_FILTER_ASYM_EN defined:
  - alpha = coeff_rise_i when d > 0.
  - alpha = coeff_fall_i when d ≤ 0.
- Not defined:
  - alpha = coeff_rise_i always.
  - coeff_fall_i is present but ignored.

## Test plan
All scenarios use WIDTH=5, CHANNELS=4.
- Reset: assert reset mid-RUN → value_o=0, valid_o=0, ready_o=1 immediately. No valid_o follows after release.
- Snap: clear_i=1 with inputs {31,0,16,5} → valid_o exactly 7 cycles after the handshake, value_o={31,0,16,5}. ready_o is low for cycles 1–6.
- Step: from state 0, input 31 on all channels with rise=fall=32768 → output 16 (y=15.5), then 23 (y=23.25) on the next vector.
- Extremes:
  - alpha=0 → output holds 23 over 10 vectors regardless of input.
  - alpha=65535, 0→31 → output 31 after one vector.
- Asymmetry: rise=65535, fall=0, input 31 then 0.
  - With LUM_FILTER_ASYM_EN: output stays 31.
  - Without it: output goes to 0.
- Backpressure: toggle valid_i and value_i while ready_o=0 → inputs ignored, result reflects only the accepted vector. Back-to-back vectors start in the valid_o cycle.
